zynq_frame_packer: RTL and testbench

ZYNQ_FRAME_PACKER -- requirements
Module: zynq_frame_packer

---
 rtl/zynq_frame_packer.sv | 167 ++++++++++++++++
 tb/tb_zynq_frame_packer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/zynq_frame_packer.sv
// Packs 12-bit ADC samples (two per word) into framed 32-bit events
// with header/marker/trailer words, buffered in a FWFT FIFO towards the ZYNQ.
module zynq_frame_packer #(
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned CHAN  = 8,
  localparam int unsigned CW    = (CHAN > 1) ? $clog2(CHAN) : 1,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          CK50,
  input  logic          RST,
  input  logic          EOS,
  input  logic          DONE,
  input  logic [15:0]   DIN,
  input  logic          DIN_VALID,
  input  logic [CW-1:0] CHAN_ID,
  output logic          DIN_READY,
  output logic [31:0]   DOUT,
  output logic          DOUT_VALID,
  input  logic          DOUT_READY,
  output logic [15:0]   EVT_CNT,
  output logic          EOS_ERR
);

  typedef enum logic [2:0] {IDLE, HEADER, DATA, MARKER, FLUSH, TRAILER} state_t;

  state_t        state_q, state_d;
  logic [15:0]   held_q, held_d;
  logic          pend_q, pend_d;
  logic [CW-1:0] lastc_q, lastc_d;
  logic          lastv_q, lastv_d;
  logic [15:0]   wcnt_q, wcnt_d;
  logic [15:0]   evt_q, evt_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic          ftrl_q, ftrl_d;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          full, empty, push, pop;
  logic [31:0]   wdata;
  logic [15:0]   wcnt_inc;
  logic          chan_match, done_evt;

  assign full       = (cnt_q == (AW+1)'(DEPTH));
  assign empty      = (cnt_q == '0);
  assign pop        = DOUT_READY && !empty;
  assign wcnt_inc   = (wcnt_q == 16'hFFFF) ? wcnt_q : wcnt_q + 16'd1;
  assign chan_match = lastv_q && (CHAN_ID == lastc_q);
  assign done_evt   = DONE || done_q;

  always_comb begin
    state_d   = state_q;
    held_d    = held_q;
    pend_d    = pend_q;
    lastc_d   = lastc_q;
    lastv_d   = lastv_q;
    wcnt_d    = wcnt_q;
    evt_d     = evt_q;
    ftrl_d    = ftrl_q;
    err_d     = err_q | (EOS && state_q != IDLE);
    done_d    = done_q | (DONE && state_q != IDLE && state_q != TRAILER);
    push      = 1'b0;
    wdata     = '0;
    DIN_READY = 1'b0;
    case (state_q)
      IDLE: if (EOS) state_d = HEADER;
      HEADER: if (!full) begin
        push    = 1'b1;
        wdata   = {8'hA5, evt_q, 8'h00};
        wcnt_d  = 16'd1;
        pend_d  = 1'b0;
        lastv_d = 1'b0;
        state_d = DATA;
      end
      DATA: begin
        // DONE (live or latched while blocked elsewhere) wins over any sample
        if (done_evt) begin
          done_d  = 1'b0;
          ftrl_d  = 1'b1;
          state_d = pend_q ? FLUSH : TRAILER;
        end else begin
          DIN_READY = !full && chan_match;
          if (DIN_VALID && !chan_match) begin
            ftrl_d  = 1'b0;
            state_d = pend_q ? FLUSH : MARKER;
          end else if (DIN_VALID && DIN_READY) begin
            if (pend_q) begin
              push   = 1'b1;
              wdata  = {held_q, DIN};
              pend_d = 1'b0;
              wcnt_d = wcnt_inc;
            end else begin
              held_d = DIN;
              pend_d = 1'b1;
            end
          end
        end
      end
      MARKER: if (!full) begin
        push    = 1'b1;
        wdata   = {8'hC3, 24'(CHAN_ID)};
        wcnt_d  = wcnt_inc;
        lastc_d = CHAN_ID;
        lastv_d = 1'b1;
        state_d = DATA;
      end
      FLUSH: if (!full) begin
        push    = 1'b1;
        wdata   = {held_q, 16'h0000};
        wcnt_d  = wcnt_inc;
        pend_d  = 1'b0;
        state_d = ftrl_q ? TRAILER : MARKER;
      end
      TRAILER: if (!full) begin
        push    = 1'b1;
        wdata   = {8'h5A, 8'h00, wcnt_q};
        evt_d   = evt_q + 16'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CK50) begin
    if (RST) begin
      state_q <= IDLE;
      held_q  <= '0;
      pend_q  <= 1'b0;
      lastc_q <= '0;
      lastv_q <= 1'b0;
      wcnt_q  <= '0;
      evt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      ftrl_q  <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      pend_q  <= pend_d;
      lastc_q <= lastc_d;
      lastv_q <= lastv_d;
      wcnt_q  <= wcnt_d;
      evt_q   <= evt_d;
      err_q   <= err_d;
      done_q  <= done_d;
      ftrl_q  <= ftrl_d;
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      if (push && !pop)      cnt_q <= cnt_q + (AW+1)'(1);
      else if (!push && pop) cnt_q <= cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge CK50) begin
    if (push) mem_q[wptr_q] <= wdata;
  end

  assign DOUT       = empty ? '0 : mem_q[rptr_q];
  assign DOUT_VALID = !empty;
  assign EVT_CNT    = evt_q;
  assign EOS_ERR    = err_q;

endmodule

// File: tb/tb_zynq_frame_packer.sv
// Directed bench for zynq_frame_packer: frames are collected from the output
// handshake and compared word by word against hand-derived values.
module tb_zynq_frame_packer;

  logic        CK50 = 1'b0;
  logic        RST, EOS, DONE, DIN_VALID, DOUT_READY;
  logic [15:0] DIN;
  logic [2:0]  CHAN_ID;
  logic        DIN_READY, DOUT_VALID, EOS_ERR;
  logic [31:0] DOUT;
  logic [15:0] EVT_CNT;

  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];

  zynq_frame_packer #(.DEPTH(16), .CHAN(8)) dut (
    .CK50(CK50), .RST(RST), .EOS(EOS), .DONE(DONE), .DIN(DIN),
    .DIN_VALID(DIN_VALID), .CHAN_ID(CHAN_ID), .DIN_READY(DIN_READY),
    .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .DOUT_READY(DOUT_READY),
    .EVT_CNT(EVT_CNT), .EOS_ERR(EOS_ERR)
  );

  always #5 CK50 = ~CK50;

  // Word observed here is the one popped at the following rising edge.
  always @(negedge CK50) if (!RST && DOUT_VALID && DOUT_READY) q.push_back(DOUT);

  function automatic logic [15:0] smp(input int i);
    logic [31:0] v;
    v = i;
    return {v[11:0], 4'h0};
  endfunction

  task automatic tick;
    @(posedge CK50); #1;
  endtask

  task automatic do_reset;
    RST = 1'b1; tick; RST = 1'b0;
  endtask

  task automatic pulse_eos;
    EOS = 1'b1; tick; EOS = 1'b0;
  endtask

  task automatic pulse_done;
    DONE = 1'b1; tick; DONE = 1'b0;
  endtask

  task automatic send(input logic [2:0] ch, input logic [15:0] d);
    logic acc;
    CHAN_ID = ch; DIN = d; DIN_VALID = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge CK50);
      acc = DIN_READY;
      tick;
      if (acc) begin
        DIN_VALID = 1'b0;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL send_timeout: sample %h ch %0d not accepted, required accept within 200 cycles", d, ch);
    DIN_VALID = 1'b0;
  endtask

  task automatic wait_words(input int n);
    for (int i = 0; i < 200 && q.size() < n; i++) @(negedge CK50);
    repeat (4) @(negedge CK50);
  endtask

  task automatic test_reset;
    RST = 1'b1; EOS = 0; DONE = 0; DIN_VALID = 0; DOUT_READY = 0; DIN = '0; CHAN_ID = '0;
    repeat (3) tick;
    @(negedge CK50);
    checks++; if (DOUT_VALID !== 1'b0) begin errors++; $display("FAIL rst_dout_valid got %b want 0", DOUT_VALID); end
    checks++; if (DIN_READY !== 1'b0) begin errors++; $display("FAIL rst_din_ready got %b want 0", DIN_READY); end
    checks++; if (DOUT !== 32'h0) begin errors++; $display("FAIL rst_dout got %h want 00000000", DOUT); end
    checks++; if (EVT_CNT !== 16'h0) begin errors++; $display("FAIL rst_evt_cnt got %h want 0000", EVT_CNT); end
    checks++; if (EOS_ERR !== 1'b0) begin errors++; $display("FAIL rst_eos_err got %b want 0", EOS_ERR); end
    tick; RST = 1'b0;
  endtask

  task automatic test_basic_frame;
    logic [31:0] exp [4] = '{32'hA5000000, 32'hC3000002, 32'h12304560, 32'h5A000003};
    logic [31:0] got;
    q.delete(); DOUT_READY = 1'b1;
    pulse_eos;
    send(3'd2, 16'h1230);
    send(3'd2, 16'h4560);
    @(negedge CK50);
    checks++; if (DOUT_VALID !== 1'b1 || DOUT !== 32'h12304560) begin
      errors++; $display("FAIL pair_latency got valid=%b dout=%h want valid=1 dout=12304560", DOUT_VALID, DOUT); end
    tick;
    pulse_done;
    wait_words(4);
    checks++; if (q.size() != 4) begin errors++; $display("FAIL basic_count got %0d want 4", q.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < q.size()) ? q[i] : 32'hxxxxxxxx;
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL basic_word%0d got %h want %h", i, got, exp[i]); end
    end
    checks++; if (EVT_CNT !== 16'd1) begin errors++; $display("FAIL basic_evt_cnt got %0d want 1", EVT_CNT); end
  endtask

  task automatic test_channel_change;
    logic [31:0] exp [6] = '{32'hA5000100, 32'hC3000000, 32'hAAA00000,
                             32'hC3000001, 32'hBBB00000, 32'h5A000005};
    logic [31:0] got;
    q.delete(); DOUT_READY = 1'b1;
    pulse_eos;
    send(3'd0, 16'hAAA0);
    send(3'd1, 16'hBBB0);
    pulse_done;
    wait_words(6);
    checks++; if (q.size() != 6) begin errors++; $display("FAIL chg_count got %0d want 6", q.size()); end
    for (int i = 0; i < 6; i++) begin
      got = (i < q.size()) ? q[i] : 32'hxxxxxxxx;
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL chg_word%0d got %h want %h", i, got, exp[i]); end
    end
    checks++; if (EVT_CNT !== 16'd2) begin errors++; $display("FAIL chg_evt_cnt got %0d want 2", EVT_CNT); end
  endtask

  task automatic test_fifo_full;
    logic [31:0] got, want;
    do_reset; q.delete(); DOUT_READY = 1'b0;
    pulse_eos;
    for (int i = 1; i <= 28; i++) send(3'd0, smp(i));
    CHAN_ID = 3'd0; DIN = smp(29); DIN_VALID = 1'b1;
    repeat (4) tick;
    @(negedge CK50);
    checks++; if (DOUT_VALID !== 1'b1) begin errors++; $display("FAIL full_dout_valid got %b want 1", DOUT_VALID); end
    checks++; if (DIN_READY !== 1'b0) begin errors++; $display("FAIL full_din_ready got %b want 0", DIN_READY); end
    checks++; if (DOUT !== 32'hA5000000) begin errors++; $display("FAIL full_head got %h want A5000000", DOUT); end
    tick;
    DOUT_READY = 1'b1;
    for (int i = 29; i <= 40; i++) send(3'd0, smp(i));
    pulse_done;
    wait_words(23);
    checks++; if (q.size() != 23) begin errors++; $display("FAIL full_count got %0d want 23", q.size()); end
    for (int i = 0; i < 23; i++) begin
      if (i == 0) want = 32'hA5000000;
      else if (i == 1) want = 32'hC3000000;
      else if (i == 22) want = 32'h5A000016;
      else want = {smp(2*(i-2)+1), smp(2*(i-2)+2)};
      got = (i < q.size()) ? q[i] : 32'hxxxxxxxx;
      checks++; if (got !== want) begin errors++; $display("FAIL full_word%0d got %h want %h", i, got, want); end
    end
  endtask

  task automatic test_eos_error;
    logic [31:0] exp [4] = '{32'hA5000000, 32'hC3000003, 32'h77708880, 32'h5A000003};
    logic [31:0] got;
    do_reset; q.delete(); DOUT_READY = 1'b1;
    pulse_eos;
    send(3'd3, 16'h7770);
    pulse_eos;
    @(negedge CK50);
    checks++; if (EOS_ERR !== 1'b1) begin errors++; $display("FAIL eos_err_set got %b want 1", EOS_ERR); end
    tick;
    send(3'd3, 16'h8880);
    pulse_done;
    wait_words(4);
    checks++; if (q.size() != 4) begin errors++; $display("FAIL eos_count got %0d want 4", q.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < q.size()) ? q[i] : 32'hxxxxxxxx;
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL eos_word%0d got %h want %h", i, got, exp[i]); end
    end
    do_reset;
    @(negedge CK50);
    checks++; if (EOS_ERR !== 1'b0) begin errors++; $display("FAIL eos_err_clear got %b want 0", EOS_ERR); end
    tick;
  endtask

  task automatic test_reset_mid_event;
    logic [31:0] got;
    do_reset; q.delete(); DOUT_READY = 1'b0;
    pulse_eos;
    for (int i = 1; i <= 6; i++) send(3'd1, smp(i));
    tick;
    @(negedge CK50);
    checks++; if (DOUT_VALID !== 1'b1) begin errors++; $display("FAIL mid_prefill_valid got %b want 1", DOUT_VALID); end
    tick;
    RST = 1'b1; tick;
    @(negedge CK50);
    checks++; if (DOUT_VALID !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", DOUT_VALID); end
    checks++; if (EVT_CNT !== 16'd0) begin errors++; $display("FAIL mid_rst_evt got %0d want 0", EVT_CNT); end
    checks++; if (DOUT !== 32'h0) begin errors++; $display("FAIL mid_rst_dout got %h want 00000000", DOUT); end
    tick; RST = 1'b0;
    q.delete(); DOUT_READY = 1'b1;
    pulse_eos;
    pulse_done;
    wait_words(2);
    checks++; if (q.size() != 2) begin errors++; $display("FAIL mid_count got %0d want 2", q.size()); end
    got = (q.size() > 0) ? q[0] : 32'hxxxxxxxx;
    checks++; if (got !== 32'hA5000000) begin errors++; $display("FAIL mid_header got %h want A5000000", got); end
    got = (q.size() > 1) ? q[1] : 32'hxxxxxxxx;
    checks++; if (got !== 32'h5A000001) begin errors++; $display("FAIL mid_trailer got %h want 5A000001", got); end
  endtask

  task automatic test_done_priority;
    logic [31:0] exp [4] = '{32'hA5000000, 32'hC3000004, 32'h11100000, 32'h5A000003};
    logic [31:0] got;
    do_reset; q.delete(); DOUT_READY = 1'b1;
    pulse_eos;
    send(3'd4, 16'h1110);
    CHAN_ID = 3'd4; DIN = 16'h2220; DIN_VALID = 1'b1; DONE = 1'b1;
    @(negedge CK50);
    checks++; if (DIN_READY !== 1'b0) begin errors++; $display("FAIL prio_din_ready got %b want 0", DIN_READY); end
    tick;
    DONE = 1'b0; DIN_VALID = 1'b0;
    wait_words(4);
    checks++; if (q.size() != 4) begin errors++; $display("FAIL prio_count got %0d want 4", q.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < q.size()) ? q[i] : 32'hxxxxxxxx;
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL prio_word%0d got %h want %h", i, got, exp[i]); end
    end
    checks++; if (EVT_CNT !== 16'd1) begin errors++; $display("FAIL prio_evt_cnt got %0d want 1", EVT_CNT); end
  endtask

  initial begin
    test_reset;
    test_basic_frame;
    test_channel_change;
    test_fifo_full;
    test_eos_error;
    test_reset_mid_event;
    test_done_priority;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
